// File: rtl/fb_sup_pkg.sv
// fb_sup_pkg: shared state, mode and trip-cause codes for the feedback loop supervisor
package fb_sup_pkg;
  localparam int CNT_W_DEF  = 8;
  localparam int PCNT_W_DEF = 16;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_ACTIVE  = 3'd2,
    S_POST    = 3'd3,
    S_TRIPPED = 3'd4
  } state_e;
  typedef enum logic [1:0] {
    M_OFF    = 2'b00,
    M_FB     = 2'b01,
    M_CDAC   = 2'b10,
    M_FB_ALT = 2'b11
  } mode_e;
  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_OFLOW   = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;
  localparam logic [1:0] TC_BOTH    = 2'b11;
endpackage

// File: rtl/fb_sat_counter.sv
// fb_sat_counter: saturating up-counter with synchronous clear
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : clear to zero (wins over increment)
//   inc_i    : increment by one unless saturated
//   cnt_o    : current count
//   sat_o    : count is all-ones
module fb_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);
  logic [W-1:0] cnt_q;
  assign cnt_o = cnt_q;
  assign sat_o = &cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i && !sat_o) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/fb_loop_supervisor.sv
// fb_loop_supervisor: per-pulse arm/gate/trip sequencer for the bunch-by-bunch feedback datapath
//   store_strb, oflow           : beam gate and datapath overflow flag
//   arm, disarm, clear_trip     : single-cycle control requests
//   continuous, mode, trip_limit: re-arm policy, output mode, per-pulse overflow limit
//   fb_en_b, const_dac_en_b     : datapath enables, high only in ACTIVE
//   state, tripped, trip_cause  : status
//   oflow_count, pulse_count, stat_valid : per-pulse statistics with update strobe
module fb_loop_supervisor
  import fb_sup_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int PCNT_W       = PCNT_W_DEF,
  parameter int GATE_TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_strb,
  input  logic              oflow,
  input  logic              arm,
  input  logic              disarm,
  input  logic              clear_trip,
  input  logic              continuous,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  trip_limit,
  output logic              fb_en_b,
  output logic              const_dac_en_b,
  output logic [2:0]        state,
  output logic              tripped,
  output logic [1:0]        trip_cause,
  output logic [CNT_W-1:0]  oflow_count,
  output logic [PCNT_W-1:0] pulse_count,
  output logic              stat_valid
);
  localparam int GW = $clog2(GATE_TIMEOUT + 1);
  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic                strb_q;
  logic                fb_q, fb_d, cd_q, cd_d, trip_q, trip_d, sv_q, sv_d;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W-1:0]    ocnt_q, ocnt_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    run_cnt, run_nx;
  logic                run_sat;
  logic [GW-1:0]       gate_cnt;
  logic [CNT_W:0]      run_sum;
  logic                act, rise, enter_act, oflow_trip, tmo_trip;
  assign act       = state_q == S_ACTIVE;
  assign rise      = store_strb && !strb_q;
  assign enter_act = state_q == S_ARMED && rise && !disarm;
  fb_sat_counter #(.W(CNT_W)) u_run (
    .clk(clk), .rst(rst), .clr_i(enter_act), .inc_i(act && oflow),
    .cnt_o(run_cnt), .sat_o(run_sat)
  );
  fb_sat_counter #(.W(GW)) u_gate (
    .clk(clk), .rst(rst), .clr_i(enter_act), .inc_i(act),
    .cnt_o(gate_cnt), .sat_o()
  );
  // Unsaturated sum for the limit compare; saturated value for what gets reported.
  assign run_sum    = {1'b0, run_cnt} + (CNT_W+1)'(oflow);
  assign run_nx     = run_sat ? run_cnt : run_cnt + CNT_W'(oflow);
  assign oflow_trip = act && trip_limit != '0 && run_sum >= {1'b0, trip_limit};
  assign tmo_trip   = act && gate_cnt == GW'(GATE_TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cause_d = cause_q;
    ocnt_d  = ocnt_q;
    pcnt_d  = pcnt_q;
    sv_d    = 1'b0;
    case (state_q)
      S_IDLE: if (arm && !disarm) begin
        state_d = S_ARMED;
        mode_d  = mode;
      end
      S_ARMED: state_d = disarm ? S_IDLE : rise ? S_ACTIVE : S_ARMED;
      S_ACTIVE: begin
        if (oflow_trip || tmo_trip) begin
          state_d = S_TRIPPED;
          cause_d = {tmo_trip, oflow_trip};
          ocnt_d  = run_nx;
          sv_d    = 1'b1;
        end else if (disarm) begin
          state_d = S_IDLE;
        end else if (!store_strb) begin
          state_d = S_POST;
          ocnt_d  = run_nx;
          pcnt_d  = pcnt_q + 1'b1;
          sv_d    = 1'b1;
        end
      end
      S_POST: begin
        state_d = continuous ? S_ARMED : S_IDLE;
        mode_d  = continuous ? mode : mode_q;
      end
      S_TRIPPED: if (clear_trip) begin
        state_d = S_IDLE;
        cause_d = TC_NONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Enables follow the next state so they are registered yet aligned with ACTIVE.
    fb_d   = state_d == S_ACTIVE && mode_d[0];
    cd_d   = state_d == S_ACTIVE && mode_d == M_CDAC;
    trip_d = state_d == S_TRIPPED;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_OFF;
      strb_q  <= 1'b0;
      fb_q    <= 1'b0;
      cd_q    <= 1'b0;
      trip_q  <= 1'b0;
      sv_q    <= 1'b0;
      cause_q <= TC_NONE;
      ocnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      strb_q  <= store_strb;
      fb_q    <= fb_d;
      cd_q    <= cd_d;
      trip_q  <= trip_d;
      sv_q    <= sv_d;
      cause_q <= cause_d;
      ocnt_q  <= ocnt_d;
      pcnt_q  <= pcnt_d;
    end
  end
  assign fb_en_b        = fb_q;
  assign const_dac_en_b = cd_q;
  assign state          = state_q;
  assign tripped        = trip_q;
  assign trip_cause     = cause_q;
  assign oflow_count    = ocnt_q;
  assign pulse_count    = pcnt_q;
  assign stat_valid     = sv_q;
endmodule

// File: tb/tb_fb_loop_supervisor.sv
// tb_fb_loop_supervisor: directed bench with a per-cycle reference model for two timeout settings
module tb_fb_loop_supervisor;
  logic clk = 1'b0;
  logic rst, store_strb, oflow, arm, disarm, clear_trip, continuous;
  logic [1:0] mode;
  logic [7:0] trip_limit;
  logic fb_a, cd_a, tr_a, sv_a, fb_b, cd_b, tr_b, sv_b;
  logic [2:0] st_a, st_b;
  logic [1:0] tc_a, tc_b;
  logic [7:0] oc_a, oc_b;
  logic [15:0] pc_a, pc_b;
  int n_chk = 0, n_fail = 0;
  int nfa = 0, nca = 0, nsa = 0, nfb = 0;
  int sfa, sca, ssa, sfb;

  always #5 clk = ~clk;

  fb_loop_supervisor #(.CNT_W(8), .PCNT_W(16), .GATE_TIMEOUT(4095)) dut_a (
    .clk(clk), .rst(rst), .store_strb(store_strb), .oflow(oflow), .arm(arm),
    .disarm(disarm), .clear_trip(clear_trip), .continuous(continuous), .mode(mode),
    .trip_limit(trip_limit), .fb_en_b(fb_a), .const_dac_en_b(cd_a), .state(st_a),
    .tripped(tr_a), .trip_cause(tc_a), .oflow_count(oc_a), .pulse_count(pc_a),
    .stat_valid(sv_a));
  fb_loop_supervisor #(.CNT_W(8), .PCNT_W(16), .GATE_TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .store_strb(store_strb), .oflow(oflow), .arm(arm),
    .disarm(disarm), .clear_trip(clear_trip), .continuous(continuous), .mode(mode),
    .trip_limit(trip_limit), .fb_en_b(fb_b), .const_dac_en_b(cd_b), .state(st_b),
    .tripped(tr_b), .trip_cause(tc_b), .oflow_count(oc_b), .pulse_count(pc_b),
    .stat_valid(sv_b));

  // Reference model: phase 0..4, latched mode, per-pulse tallies and published stats.
  typedef struct {
    int st, md, run, gate, cause, ocnt, pcnt;
    bit prev, sv;
  } mdl_t;
  mdl_t ma, mb, mz;

  function automatic mdl_t step(mdl_t m, int tmo);
    mdl_t n = m;
    int sum;
    bit ot, tt;
    n.sv = 0;
    n.prev = store_strb;
    if (m.st == 0) begin
      if (arm && !disarm) begin n.st = 1; n.md = int'(mode); end
    end else if (m.st == 1) begin
      if (disarm) n.st = 0;
      else if (store_strb && !m.prev) begin n.st = 2; n.run = 0; n.gate = 0; end
    end else if (m.st == 2) begin
      sum = m.run + int'(oflow);
      ot = trip_limit != 0 && sum >= int'(trip_limit);
      tt = m.gate == tmo - 1;
      n.run = sum > 255 ? 255 : sum;
      n.gate = m.gate + 1;
      if (ot || tt) begin
        n.st = 4; n.cause = (tt ? 2 : 0) + (ot ? 1 : 0); n.ocnt = n.run; n.sv = 1;
      end else if (disarm) n.st = 0;
      else if (!store_strb) begin
        n.st = 3; n.ocnt = n.run; n.pcnt = (m.pcnt + 1) % 65536; n.sv = 1;
      end
    end else if (m.st == 3) begin
      n.st = continuous ? 1 : 0;
      if (continuous) n.md = int'(mode);
    end else if (m.st == 4) begin
      if (clear_trip) begin n.st = 0; n.cause = 0; end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, a, e);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin ma = mz; mb = mz; end
    else begin ma = step(ma, 4095); mb = step(mb, 16); end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("a_state", 32'(st_a), ma.st);
      chk("a_fb_en", 32'(fb_a), (ma.st == 2 && (ma.md == 1 || ma.md == 3)) ? 1 : 0);
      chk("a_cdac_en", 32'(cd_a), (ma.st == 2 && ma.md == 2) ? 1 : 0);
      chk("a_tripped", 32'(tr_a), ma.st == 4 ? 1 : 0);
      chk("a_cause", 32'(tc_a), ma.cause);
      chk("a_oflow_count", 32'(oc_a), ma.ocnt);
      chk("a_pulse_count", 32'(pc_a), ma.pcnt);
      chk("a_stat_valid", 32'(sv_a), 32'(ma.sv));
      chk("b_state", 32'(st_b), mb.st);
      chk("b_fb_en", 32'(fb_b), (mb.st == 2 && (mb.md == 1 || mb.md == 3)) ? 1 : 0);
      chk("b_cdac_en", 32'(cd_b), (mb.st == 2 && mb.md == 2) ? 1 : 0);
      chk("b_tripped", 32'(tr_b), mb.st == 4 ? 1 : 0);
      chk("b_cause", 32'(tc_b), mb.cause);
      chk("b_oflow_count", 32'(oc_b), mb.ocnt);
      chk("b_pulse_count", 32'(pc_b), mb.pcnt);
      chk("b_stat_valid", 32'(sv_b), 32'(mb.sv));
      chk("a_en_exclusive", 32'(fb_a & cd_a), 0);
    end
    if (fb_a) nfa++;
    if (cd_a) nca++;
    if (sv_a) nsa++;
    if (fb_b) nfb++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1; cyc(); arm = 0;
  endtask

  task automatic pulse_clear();
    clear_trip = 1; cyc(); clear_trip = 0;
  endtask

  initial begin
    rst = 1; store_strb = 0; oflow = 0; arm = 0; disarm = 0; clear_trip = 0;
    continuous = 0; mode = 2'b00; trip_limit = 8'd0;
    cyc(2);
    chk("reset_state", 32'(st_a), 0);
    chk("reset_pulse_count", 32'(pc_a), 0);
    rst = 0;
    cyc();
    // 1: asynchronous reset while feedback is enabled
    mode = 2'b01; pulse_arm();
    store_strb = 1; cyc();
    chk("t1_fb_on", 32'(fb_a), 1);
    cyc(3);
    #3 rst = 1;
    #1;
    chk("t1_async_state", 32'(st_a), 0);
    chk("t1_async_fb", 32'(fb_a), 0);
    chk("t1_async_ocnt", 32'(oc_a), 0);
    store_strb = 0;
    cyc();
    rst = 0;
    cyc();
    // 2: 100-cycle gate, three overflow cycles, single shot
    mode = 2'b01; continuous = 0; trip_limit = 0;
    pulse_arm(); cyc(2);
    sfa = nfa; ssa = nsa;
    store_strb = 1;
    for (int i = 0; i < 100; i++) begin
      oflow = (i == 10 || i == 20 || i == 30);
      cyc();
    end
    store_strb = 0; oflow = 0;
    cyc(4);
    chk("t2_fb_cycles", 32'(nfa - sfa), 100);
    chk("t2_stat_strobes", 32'(nsa - ssa), 1);
    chk("t2_oflow_count", 32'(oc_a), 3);
    chk("t2_pulse_count", 32'(pc_a), 1);
    chk("t2_final_state", 32'(st_a), 0);
    chk("t2_b_timeout_cause", 32'(tc_b), 2);
    pulse_clear(); cyc();
    // 3: overflow trip at limit 5
    trip_limit = 8'd5;
    pulse_arm(); cyc(2);
    sfa = nfa;
    store_strb = 1;
    for (int i = 0; i < 20; i++) begin
      oflow = (i >= 2);
      cyc();
    end
    chk("t3_state", 32'(st_a), 4);
    chk("t3_cause", 32'(tc_a), 1);
    chk("t3_oflow_count", 32'(oc_a), 5);
    chk("t3_pulse_count", 32'(pc_a), 1);
    chk("t3_fb_cycles", 32'(nfa - sfa), 6);
    store_strb = 0; oflow = 0;
    pulse_arm(); cyc();
    chk("t3_arm_ignored", 32'(st_a), 4);
    pulse_clear();
    chk("t3_cleared_state", 32'(st_a), 0);
    chk("t3_cleared_cause", 32'(tc_a), 0);
    cyc();
    // 4: gate timeout on the short-timeout instance, then simultaneous causes
    trip_limit = 0;
    pulse_arm(); cyc(2);
    sfb = nfb;
    store_strb = 1; cyc(40);
    store_strb = 0; cyc(3);
    chk("t4_b_fb_cycles", 32'(nfb - sfb), 16);
    chk("t4_b_cause", 32'(tc_b), 2);
    chk("t4_a_pulse_count", 32'(pc_a), 2);
    pulse_clear(); cyc();
    trip_limit = 8'd16;
    pulse_arm(); cyc(2);
    store_strb = 1; oflow = 1; cyc(40);
    store_strb = 0; oflow = 0; cyc(2);
    chk("t4_b_both_cause", 32'(tc_b), 3);
    chk("t4_b_oflow_count", 32'(oc_b), 16);
    chk("t4_a_oflow_cause", 32'(tc_a), 1);
    pulse_clear(); cyc();
    // 5: arm with gate already high, then continuous constant-DAC gates
    rst = 1; cyc(); rst = 0; cyc();
    store_strb = 1; cyc(2);
    mode = 2'b10; continuous = 1; trip_limit = 0;
    pulse_arm(); cyc(4);
    chk("t5_partial_state", 32'(st_a), 1);
    chk("t5_partial_cdac", 32'(cd_a), 0);
    store_strb = 0; cyc(3);
    sca = nca; sfa = nfa;
    for (int g = 0; g < 3; g++) begin
      store_strb = 1; cyc(10);
      store_strb = 0; cyc(4);
    end
    chk("t5_cdac_cycles", 32'(nca - sca), 30);
    chk("t5_fb_cycles", 32'(nfa - sfa), 0);
    chk("t5_pulse_count", 32'(pc_a), 3);
    chk("t5_end_state", 32'(st_a), 1);
    disarm = 1; cyc(); disarm = 0; continuous = 0;
    chk("t5_disarmed", 32'(st_a), 0);
    // 6: arm+disarm together, then disarm mid-gate
    arm = 1; disarm = 1; cyc(); arm = 0; disarm = 0;
    chk("t6_arm_disarm", 32'(st_a), 0);
    mode = 2'b01;
    pulse_arm(); cyc();
    store_strb = 1; cyc(5);
    chk("t6_active", 32'(st_a), 2);
    ssa = nsa;
    disarm = 1; cyc(); disarm = 0;
    chk("t6_disarm_state", 32'(st_a), 0);
    chk("t6_disarm_fb", 32'(fb_a), 0);
    cyc(2);
    chk("t6_no_stat", 32'(nsa - ssa), 0);
    store_strb = 0; cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
